// File: rtl/d_branch_resolve.sv
// Decode-stage branch condition evaluation, BHT prediction/training and branch statistics.
// Latency: f_pred_taken/jump/link/mispredict are combinational; BHT and counters update on the next clk edge.
// Backpressure: none; d_valid qualifies exactly one update per instruction, a stalled stage holds d_valid low.
module d_branch_resolve #(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CTR_W     = 2,
    parameter int STAT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       f_pc,
    output logic              f_pred_taken,
    input  logic              d_valid,
    input  logic [31:0]       d_pc,
    input  logic [3:0]        d_cmp_op,
    input  logic              d_pred_taken,
    input  logic [WIDTH-1:0]  rs,
    input  logic [WIDTH-1:0]  rt,
    output logic              jump,
    output logic              link,
    output logic              mispredict,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    localparam logic [3:0] OP_BEQ    = 4'd1;
    localparam logic [3:0] OP_BNE    = 4'd2;
    localparam logic [3:0] OP_BLEZ   = 4'd3;
    localparam logic [3:0] OP_BGTZ   = 4'd4;
    localparam logic [3:0] OP_BLTZ   = 4'd5;
    localparam logic [3:0] OP_BGEZ   = 4'd6;
    localparam logic [3:0] OP_BLTZAL = 4'd7;
    localparam logic [3:0] OP_BGEZAL = 4'd8;

    // Saturation limits; the reset value is the weakly-not-taken point just below the MSB.
    localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0]  CTR_INIT = CTR_MAX >> 1;
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    logic [CTR_W-1:0] bht [BHT_DEPTH];

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] d_idx;
    logic [CTR_W-1:0] d_ctr;
    logic             rs_neg;
    logic             rs_zero;
    logic             rs_eq;
    logic             is_br;

    // PC bits outside the index field are intentionally ignored (aliasing is accepted).
    logic unused_pc;
    assign unused_pc = ^{f_pc[31:IDX_W+2], f_pc[1:0], d_pc[31:IDX_W+2], d_pc[1:0]};

    assign f_idx        = f_pc[IDX_W+1:2];
    assign d_idx        = d_pc[IDX_W+1:2];
    assign d_ctr        = bht[d_idx];
    assign f_pred_taken = bht[f_idx][CTR_W-1];

    // Signed comparisons reduce to sign bit, zero test and equality.
    assign rs_neg  = rs[WIDTH-1];
    assign rs_zero = (rs == '0);
    assign rs_eq   = (rs == rt);

    // Condition select and link decode; independent of d_valid.
    always_comb begin
        jump = 1'b0;
        link = 1'b0;
        case (d_cmp_op)
            OP_BEQ:    jump = rs_eq;
            OP_BNE:    jump = !rs_eq;
            OP_BLEZ:   jump = rs_neg || rs_zero;
            OP_BGTZ:   jump = !rs_neg && !rs_zero;
            OP_BLTZ:   jump = rs_neg;
            OP_BGEZ:   jump = !rs_neg;
            OP_BLTZAL: begin
                jump = rs_neg;
                link = 1'b1;
            end
            OP_BGEZAL: begin
                jump = !rs_neg;
                link = 1'b1;
            end
            default:   jump = 1'b0;
        endcase
    end

    assign is_br      = d_valid && (d_cmp_op >= OP_BEQ) && (d_cmp_op <= OP_BGEZAL);
    assign mispredict = is_br && (jump != d_pred_taken) && !reset;

    // BHT training: one saturating step on the D-stage entry per resolved branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= CTR_INIT;
            end
        end else if (is_br) begin
            if (jump) begin
                if (d_ctr != CTR_MAX) begin
                    bht[d_idx] <= d_ctr + CTR_W'(1);
                end
            end else begin
                if (d_ctr != '0) begin
                    bht[d_idx] <= d_ctr - CTR_W'(1);
                end
            end
        end
    end

    // Saturating branch and mispredict statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (is_br && (branch_cnt != STAT_MAX)) begin
                branch_cnt <= branch_cnt + STAT_W'(1);
            end
            if (mispredict && (mispredict_cnt != STAT_MAX)) begin
                mispredict_cnt <= mispredict_cnt + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_d_branch_resolve.sv
// Bench for d_branch_resolve: decode table, BHT training/collision/gating sequences, stats saturation.
// Latency: checks combinational outputs 1ns after driving, registered state 1ns after the edge.
// Backpressure: none; expected values flow through a scoreboard queue.
module tb_d_branch_resolve;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] f_pc;
    logic        d_valid;
    logic [31:0] d_pc;
    logic [3:0]  d_cmp_op;
    logic        d_pred_taken;
    logic [31:0] rs;
    logic [31:0] rt;

    logic        f_pred_taken, jump, link, mispredict;
    logic [31:0] branch_cnt, mispredict_cnt;
    logic        f_pred_taken_s, jump_s, link_s, mispredict_s;
    logic [3:0]  branch_cnt_s, mispredict_cnt_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    d_branch_resolve dut (
        .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
        .d_valid(d_valid), .d_pc(d_pc), .d_cmp_op(d_cmp_op), .d_pred_taken(d_pred_taken),
        .rs(rs), .rt(rt), .jump(jump), .link(link), .mispredict(mispredict),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    d_branch_resolve #(.STAT_W(4)) dut_s (
        .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred_taken_s),
        .d_valid(d_valid), .d_pc(d_pc), .d_cmp_op(d_cmp_op), .d_pred_taken(d_pred_taken),
        .rs(rs), .rt(rt), .jump(jump_s), .link(link_s), .mispredict(mispredict_s),
        .branch_cnt(branch_cnt_s), .mispredict_cnt(mispredict_cnt_s)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs_v;
        logic [31:0] rt_v;
        logic        jump_e;
        logic        link_e;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[$];

    task automatic push(input string n, input logic [31:0] e);
        exp_t x;
        x.name = n;
        x.exp  = e;
        sbq.push_back(x);
    endtask

    task automatic pop_chk(input logic [31:0] act);
        exp_t x;
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL sb_underflow actual=%0h with no expectation queued", act);
        end else begin
            x = sbq.pop_front();
            if (act !== x.exp) begin
                failures++;
                $display("FAIL %s actual=%0h required=%0h", x.name, act, x.exp);
            end
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic pred);
        d_valid      = v;
        d_pc         = pc;
        d_cmp_op     = op;
        rs           = a;
        rt           = b;
        d_pred_taken = pred;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rs_set [3];
        logic [31:0] rt_set [2];
        logic [2:0]  mask;
        logic [3:0]  tk_pred_pre, nt_pred_pre;
        logic [1:0]  tk_ctr [4];
        logic [1:0]  nt_ctr [4];
        vec_t        v;

        rs_set[0] = 32'hFFFF_FFFF; rs_set[1] = 32'd0; rs_set[2] = 32'd5;
        rt_set[0] = 32'd5;         rt_set[1] = 32'd7;
        tk_pred_pre = 4'b1110;     nt_pred_pre = 4'b0011;  // bit k = cycle k
        tk_ctr[0] = 2'd2; tk_ctr[1] = 2'd3; tk_ctr[2] = 2'd3; tk_ctr[3] = 2'd3;
        nt_ctr[0] = 2'd2; nt_ctr[1] = 2'd1; nt_ctr[2] = 2'd0; nt_ctr[3] = 2'd0;

        // Decode table: mask bit r is jump for rs_set[r] (rt-independent ops).
        for (int op = 0; op < 16; op++) begin
            case (op)
                3:       mask = 3'b011;
                4:       mask = 3'b100;
                5, 7:    mask = 3'b001;
                6, 8:    mask = 3'b110;
                default: mask = 3'b000;
            endcase
            for (int r = 0; r < 3; r++) begin
                for (int t = 0; t < 2; t++) begin
                    v.op     = 4'(op);
                    v.rs_v   = rs_set[r];
                    v.rt_v   = rt_set[t];
                    v.link_e = (op == 7) || (op == 8);
                    if (op == 1)      v.jump_e = (r == 2) && (t == 0);
                    else if (op == 2) v.jump_e = !((r == 2) && (t == 0));
                    else              v.jump_e = mask[r];
                    vecs.push_back(v);
                end
            end
        end
        vecs.push_back('{4'd4, 32'h8000_0000, 32'd0, 1'b0, 1'b0});
        vecs.push_back('{4'd3, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b0});
        vecs.push_back('{4'd6, 32'h7FFF_FFFF, 32'd0, 1'b1, 1'b0});
        vecs.push_back('{4'd5, 32'h8000_0000, 32'd0, 1'b1, 1'b0});
        vecs.push_back('{4'd1, 32'h8000_0005, 32'd5, 1'b0, 1'b0});
        vecs.push_back('{4'd2, 32'h8000_0005, 32'd5, 1'b1, 1'b0});
        vecs.push_back('{4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0});

        // Reset and initial BHT state
        reset = 1'b1;
        f_pc  = 32'd0;
        drive(1'b0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b0);
        edge1();
        edge1();
        for (int i = 0; i < 64; i++) begin
            f_pc = ($urandom() & 32'hFFFF_FF03) | (32'(i) << 2);
            #1;
            push("reset_pred", 32'd0);
            pop_chk(32'(f_pred_taken));
        end
        push("reset_branch_cnt", 32'd0);     pop_chk(branch_cnt);
        push("reset_mispredict_cnt", 32'd0); pop_chk(mispredict_cnt);
        reset = 1'b0;
        edge1();

        // Condition decode, d_valid low so the BHT stays untouched
        foreach (vecs[i]) begin
            drive(1'b0, 32'h0000_3010, vecs[i].op, vecs[i].rs_v, vecs[i].rt_v, 1'b0);
            push("decode_jump", 32'(vecs[i].jump_e));
            push("decode_link", 32'(vecs[i].link_e));
            push("decode_mispredict_invalid", 32'd0);
            #1;
            pop_chk(32'(jump));
            pop_chk(32'(link));
            pop_chk(32'(mispredict));
        end
        edge1();

        // Training: 4 taken then 4 not-taken at 0x3000 (index 0)
        f_pc = 32'h0000_3000;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h0000_3000, 4'd1, 32'd5, 32'd5, 1'b0);
            push("train_tk_pred_pre", 32'(tk_pred_pre[k]));
            push("train_tk_mispredict", 32'd1);
            #1;
            pop_chk(32'(f_pred_taken));
            pop_chk(32'(mispredict));
            push("train_tk_ctr", 32'(tk_ctr[k]));
            edge1();
            pop_chk(32'(dut.bht[0]));
        end
        push("train_tk_mispredict_cnt", 32'd4); pop_chk(mispredict_cnt);
        push("train_tk_branch_cnt", 32'd4);     pop_chk(branch_cnt);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h0000_3000, 4'd1, 32'd5, 32'd7, 1'b0);
            push("train_nt_pred_pre", 32'(nt_pred_pre[k]));
            push("train_nt_mispredict", 32'd0);
            #1;
            pop_chk(32'(f_pred_taken));
            pop_chk(32'(mispredict));
            push("train_nt_ctr", 32'(nt_ctr[k]));
            edge1();
            pop_chk(32'(dut.bht[0]));
        end
        push("train_nt_branch_cnt", 32'd8);     pop_chk(branch_cnt);
        push("train_nt_mispredict_cnt", 32'd4); pop_chk(mispredict_cnt);

        // Same-cycle read/write collision at 0x3004 (index 1, counter 01)
        f_pc = 32'h0000_3004;
        drive(1'b1, 32'h0000_3004, 4'd1, 32'd9, 32'd9, 1'b0);
        push("collide_pred_same_cycle", 32'd0);
        #1;
        pop_chk(32'(f_pred_taken));
        edge1();
        d_valid = 1'b0;
        push("collide_pred_next_cycle", 32'd1);
        #1;
        pop_chk(32'(f_pred_taken));
        push("collide_branch_cnt", 32'd9);     pop_chk(branch_cnt);
        push("collide_mispredict_cnt", 32'd5); pop_chk(mispredict_cnt);

        // Gating: taken branch held with d_valid low for 3 cycles at 0x3008 (index 2)
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0000_3008, 4'd1, 32'd5, 32'd5, 1'b0);
            push("gate_jump", 32'd1);
            push("gate_mispredict", 32'd0);
            #1;
            pop_chk(32'(jump));
            pop_chk(32'(mispredict));
            edge1();
            push("gate_ctr", 32'd1);          pop_chk(32'(dut.bht[2]));
            push("gate_branch_cnt", 32'd9);   pop_chk(branch_cnt);
        end

        // Reset asserted while a taken BEQ is held valid at the trained index 1
        drive(1'b1, 32'h0000_3004, 4'd1, 32'd5, 32'd5, 1'b0);
        reset = 1'b1;
        push("reset_mid_mispredict", 32'd0);
        #1;
        pop_chk(32'(mispredict));
        edge1();
        edge1();
        reset   = 1'b0;
        d_valid = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) begin
            push("reset_mid_ctr", 32'd1);
            pop_chk(32'(dut.bht[i]));
        end
        push("reset_mid_branch_cnt", 32'd0);       pop_chk(branch_cnt);
        push("reset_mid_mispredict_cnt_s", 32'd0); pop_chk(32'(mispredict_cnt_s));

        // Statistics saturation: 20 mispredicted branches
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 32'(i) << 2, 4'd1, 32'd3, 32'd3, 1'b0);
            edge1();
            push("stat_branch_cnt_s", (i > 15) ? 32'd15 : 32'(i));
            push("stat_mispredict_cnt_s", (i > 15) ? 32'd15 : 32'(i));
            pop_chk(32'(branch_cnt_s));
            pop_chk(32'(mispredict_cnt_s));
        end
        d_valid = 1'b0;
        push("stat_branch_cnt_wide", 32'd20);     pop_chk(branch_cnt);
        push("stat_mispredict_cnt_wide", 32'd20); pop_chk(mispredict_cnt);

        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover actual=%0d required=0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/d_branch_resolve.md
# d_branch_resolve

Decode-stage branch resolution unit for the five-stage pipeline. It evaluates every supported conditional-branch condition on the forwarded `rs`/`rt` operands. It also owns a PC-indexed branch history table (BHT) of saturating counters: the F stage reads the BHT for a prediction, and the D stage updates it when the branch resolves. The block flags mispredictions for the flush logic and keeps saturating branch/mispredict statistics counters.

## Interface

Parameters:
- `WIDTH`, 32: operand width in bits.
- `BHT_DEPTH`, 64: number of BHT entries; must be a power of 2, ≥ 2. `IDX_W = log2(BHT_DEPTH)`.
- `CTR_W`, 2: width of each saturating counter, ≥ 1.
- `STAT_W`, 32: width of each statistics counter.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `f_pc`, in, 32: F-stage PC used for the BHT lookup.
- `f_pred_taken`, out, 1: prediction for `f_pc`; equals the MSB of the counter in entry `f_pc[IDX_W+1:2]`.
- `d_valid`, in, 1: the D-stage instruction is valid and not stalled this cycle.
- `d_pc`, in, 32: D-stage PC.
- `d_cmp_op`, in, 4: branch condition selector (encoding below).
- `d_pred_taken`, in, 1: the prediction made for this instruction in F, carried down the pipe.
- `rs`, in, `WIDTH`: forwarded rs operand.
- `rt`, in, `WIDTH`: forwarded rt operand.
- `jump`, out, 1: the branch condition is true.
- `link`, out, 1: the operation is a linking branch.
- `mispredict`, out, 1: the prediction was wrong; the pipeline must flush.
- `branch_cnt`, out, `STAT_W`: saturating count of resolved branches.
- `mispredict_cnt`, out, `STAT_W`: saturating count of mispredictions.

## Operation

`d_cmp_op` encoding and the condition each value tests (all comparisons signed):
- 0 NONE: never true.
- 1 BEQ: `rs == rt`.
- 2 BNE: `rs != rt`.
- 3 BLEZ: `rs <= 0`.
- 4 BGTZ: `rs > 0`.
- 5 BLTZ: `rs < 0`.
- 6 BGEZ: `rs >= 0`.
- 7 BLTZAL: `rs < 0`.
- 8 BGEZAL: `rs >= 0`.
- 9–15: treated as NONE.

Combinational outputs:
- `jump` = the selected condition. It is combinational and does not depend on `d_valid`.
- `link` = 1 for ops 7 and 8, regardless of the condition outcome.
- `is_br` is an internal signal: `d_valid` && op in 1..8.
- `mispredict` = `is_br` && (`jump != d_pred_taken`). Forced to 0 while `reset` is high.

BHT:
- `BHT_DEPTH` entries of `CTR_W` bits. The D-stage index is `d_pc[IDX_W+1:2]`.
- On every clock edge where `is_br` is high and `reset` is low:
  - if `jump`, the entry increments, saturating at `2^CTR_W - 1`;
  - otherwise it decrements, saturating at 0.
- Exactly one entry is updated per cycle. All other entries hold.

Statistics:
- On an edge with `is_br` high, `branch_cnt` increments by 1.
- On an edge with `mispredict` high, `mispredict_cnt` increments by 1.
- Both saturate at all-ones and never wrap.

Reset:
- Every BHT entry is set to `2^(CTR_W-1) - 1` (weakly not-taken; 01 for `CTR_W = 2`).
- Both statistics counters are set to 0.
- Updates are suppressed while `reset` is high, including a reset asserted in the middle of a run.

## Timing

- `f_pred_taken`, `jump`, `link` and `mispredict` are zero-latency combinational outputs.
- BHT reads are read-before-write. If `f_pc` and `d_pc` map to the same index in the same cycle, `f_pred_taken` shows the pre-update value. The new value is visible from the next cycle.
- The statistics counters reflect an event one cycle after it, i.e. on the edge that closes the cycle in which the event occurred.
- A D-stage instruction held across multiple cycles with `d_valid` low causes no update. The holding pipeline raises `d_valid` for exactly one cycle per instruction.
- Aliasing: PCs that differ only above bit `IDX_W+1` share an entry. This is intended behaviour.
- Reset values at the output:
  - `f_pred_taken` reads 0 for any PC when `CTR_W ≥ 2`.
  - `branch_cnt` and `mispredict_cnt` read 0.

## Test plan

- **Reset and initial BHT state.** Assert reset, then sweep `f_pc` over all `BHT_DEPTH` indices -> `f_pred_taken` = 0 everywhere; both statistics counters = 0.
- **Condition decode.** Drive all ops with `rs` in {−1, 0, 5} and `rt` in {5, 7} -> `jump` matches the signed truth table above for every combination. `link` = 1 only for ops 7 and 8, including BLTZAL with `rs` = 5 (`jump` = 0, `link` = 1). Ops 9–15 -> `jump` = 0.
- **Counter training and saturation.** Issue BEQ taken 4× at `d_pc = 0x3000` with `d_pred_taken = 0`. Expect:
  - the counter steps 01→10→11→11;
  - `f_pred_taken` at 0x3000 becomes 1 after the first edge;
  - `mispredict` is 1 on all four cycles; `mispredict_cnt` = 4.
  Then issue 4 not-taken -> the counter reaches 00 and holds.
- **Same-cycle read/write collision.** `f_pc = d_pc = 0x3004`, counter at 01, taken branch -> `f_pred_taken` = 0 in that cycle and 1 in the next.
- **Gating.** Issue a branch with `d_valid = 0` -> no BHT or statistics change and `mispredict` = 0. Assert `reset` while a taken BEQ is held valid -> no update; afterwards all entries are back at 01.
- **Statistics saturation.** With `STAT_W` = 4, issue 20 valid branches -> `branch_cnt` stops at 15.
